// File: rtl/image_memory.sv
// rtl/image_memory.sv - 28x28 signed pixel store with post-reset zero-clear sweep
//
// Purpose:
//   Holds one 28x28 image. Pixels are stored row-major, so addr = y*28 + x.
//   The store has one write port and one registered read port.
//   After every reset, a sweep writes zero to each word, one word per cycle,
//   so that every image starts blank. While the sweep runs, user writes are
//   ignored and data_out is held at 0.
//
// Optional feature:
//   Define IMAGE_MEMORY_ERR_FLAG_EN to add a sticky addr_error output. It is
//   set by any out-of-range write strobe or read address, and only resetn=0
//   clears it.
//
// Ports:
//   clk          in   system clock, rising edge
//   resetn       in   synchronous active-low reset
//   write_addr   in   write word address
//   read_addr    in   read word address
//   data_in      in   signed write data
//   write_enable in   write strobe
//   data_out     out  registered signed read data, 1-cycle latency
//   clear_busy   out  high while the zero-clear sweep runs
//   addr_error   out  (IMAGE_MEMORY_ERR_FLAG_EN only) sticky out-of-range flag

module image_memory #(
  parameter int DEPTH      = 784,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [ADDR_WIDTH-1:0]        write_addr,
  input  logic [ADDR_WIDTH-1:0]        read_addr,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         write_enable,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         clear_busy
`ifdef IMAGE_MEMORY_ERR_FLAG_EN
  ,
  output logic                         addr_error
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0] clr_ptr;
  logic             clr_last;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_fire;
  logic             same_addr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  // Range checks use the full address width, so large addresses never alias
  // onto low words through the truncated index.
  assign wr_in_range = (write_addr < ADDR_WIDTH'(DEPTH));
  assign rd_in_range = (read_addr  < ADDR_WIDTH'(DEPTH));
  assign wr_idx      = write_addr[IDX_W-1:0];
  assign rd_idx      = read_addr[IDX_W-1:0];
  assign same_addr   = (write_addr == read_addr);
  assign clr_last    = (clr_ptr == IDX_W'(DEPTH - 1));

  assign clear_busy  = (state_q == ST_CLEAR);
  assign wr_fire     = write_enable && wr_in_range && !clear_busy;

  // Sweep controller state register. Reset leaves the controller in ST_CLEAR,
  // so the sweep starts on the first edge where resetn is high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // The storage array has no reset, so it can map onto block RAM. During the
  // reset cycle itself, the array is left untouched.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (clear_busy) begin
        mem[clr_ptr] <= '0;
      end else if (wr_fire) begin
        mem[wr_idx] <= data_in;
      end
    end
  end

  // Registered read. On a same-address read and write, data_in is bypassed so
  // the read sees the newly written word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_out <= '0;
    end else if (clear_busy || !rd_in_range) begin
      data_out <= '0;
    end else if (wr_fire && same_addr) begin
      data_out <= data_in;
    end else begin
      data_out <= mem[rd_idx];
    end
  end

`ifdef IMAGE_MEMORY_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_error <= 1'b0;
    end else if ((write_enable && !wr_in_range) || !rd_in_range) begin
      addr_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_image_memory.sv
// tb/tb_image_memory.sv - self-checking bench for image_memory
module tb_image_memory;

  localparam int N = 784;

  logic               clk;
  logic               resetn;
  logic [15:0]        write_addr;
  logic [15:0]        read_addr;
  logic signed [31:0] data_in;
  logic               write_enable;
  logic signed [31:0] data_out;
  logic               clear_busy;
`ifdef IMAGE_MEMORY_ERR_FLAG_EN
  logic               addr_error;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  image_memory dut (
    .clk          (clk),
    .resetn       (resetn),
    .write_addr   (write_addr),
    .read_addr    (read_addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out),
    .clear_busy   (clear_busy)
`ifdef IMAGE_MEMORY_ERR_FLAG_EN
    ,
    .addr_error   (addr_error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the image store.
  // It tracks the pixel array, the number of words the sweep has zeroed, the
  // expected read data, the busy flag, and the sticky error flag.
  logic signed [31:0] model_mem [N];
  int                 words_cleared;
  logic signed [31:0] exp_dout;
  logic               exp_busy;
  logic               exp_err;
  logic               model_valid = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      model_valid   = 1'b1;
      exp_dout      = 0;
      exp_busy      = 1'b1;
      exp_err       = 1'b0;
      words_cleared = 0;
    end else begin
      if ((write_enable && write_addr >= N) || read_addr >= N) exp_err = 1'b1;
      if (exp_busy) begin
        model_mem[words_cleared] = 0;
        words_cleared = words_cleared + 1;
        exp_busy = (words_cleared < N);
        exp_dout = 0;
      end else begin
        if (write_enable && write_addr < N) model_mem[write_addr] = data_in;
        exp_dout = (read_addr < N) ? model_mem[read_addr] : 32'sd0;
      end
    end
  end

  // Checks the DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      n_cmp = n_cmp + 1;
      if (data_out !== exp_dout || clear_busy !== exp_busy) begin
        n_fail = n_fail + 1;
        $display("FAIL model_cmp t=%0t data_out=%0d busy=%0b expected data_out=%0d busy=%0b",
                 $time, data_out, clear_busy, exp_dout, exp_busy);
      end
`ifdef IMAGE_MEMORY_ERR_FLAG_EN
      n_cmp = n_cmp + 1;
      if (addr_error !== exp_err) begin
        n_fail = n_fail + 1;
        $display("FAIL model_err t=%0t addr_error=%0b expected %0b", $time, addr_error, exp_err);
      end
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Counts the edges until clear_busy drops. The count is bounded so the bench
  // always ends; an overrun shows up as a wrong count.
  task automatic count_sweep(output int c);
    c = 0;
    do begin
      cyc();
      c = c + 1;
    end while (clear_busy && c < 2000);
  endtask

  task automatic rd(input int a);
    read_addr = 16'(a);
    cyc();
  endtask

  task automatic wr(input int a, input logic signed [31:0] d);
    write_enable = 1'b1;
    write_addr   = 16'(a);
    data_in      = d;
    cyc();
    write_enable = 1'b0;
  endtask

  int cnt;

  initial begin
    resetn       = 1'b0;
    write_addr   = '0;
    read_addr    = '0;
    data_in      = '0;
    write_enable = 1'b0;

    // Reset, then idle through the sweep.
    cyc();
    cyc();
    chk("reset_busy", 32'(clear_busy), 32'd1);
    chk("reset_dout", data_out, 32'd0);
    resetn = 1'b1;
    count_sweep(cnt);
    chk("sweep_len", cnt, 32'd784);
    rd(0);   chk("clr_rd0",   data_out, 32'd0);
    rd(392); chk("clr_rd392", data_out, 32'd0);
    rd(783); chk("clr_rd783", data_out, 32'd0);

    // Write, then read back.
    wr(29, 32'sd1);
    wr(783, -32'sd5);
    rd(29);  chk("rd29",  data_out, 32'd1);
    rd(783); chk("rd783", data_out, 32'hFFFF_FFFB);
    wr(5, 32'hFFFF_FFFF);
    rd(5);   chk("rd_neg1", data_out, 32'hFFFF_FFFF);

    // Read during a write to the same address.
    read_addr = 16'd100;
    wr(100, 32'h1234_5678);
    chk("rdw_bypass", data_out, 32'h1234_5678);

    // Out-of-range accesses.
    wr(784, 32'sd7);
    wr(65535, 32'sd7);
    rd(784); chk("oor_rd784", data_out, 32'd0);
    rd(0);   chk("oor_rd0",   data_out, 32'd0);
`ifdef IMAGE_MEMORY_ERR_FLAG_EN
    chk("err_set", 32'(addr_error), 32'd1);
    repeat (3) cyc();
    chk("err_sticky", 32'(addr_error), 32'd1);
`endif

    // A write issued during the clear is ignored.
    resetn = 1'b0;
    cyc();
`ifdef IMAGE_MEMORY_ERR_FLAG_EN
    chk("err_cleared", 32'(addr_error), 32'd0);
`endif
    resetn       = 1'b1;
    write_enable = 1'b1;
    write_addr   = 16'd10;
    data_in      = 32'sd99;
    read_addr    = 16'd10;
    count_sweep(cnt);
    write_enable = 1'b0;
    chk("sweep_len2", cnt, 32'd784);
    rd(10); chk("wdc_rd10", data_out, 32'd0);

    // Preload data, then reset partway through a sweep.
    wr(0,   32'h0000_DEAD);
    wr(500, 32'h0000_BEEF);
    wr(783, 32'h7FFF_FFFF);
    rd(500); chk("preload500", data_out, 32'h0000_BEEF);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    repeat (400) cyc();
    chk("mid_busy", 32'(clear_busy), 32'd1);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    count_sweep(cnt);
    chk("sweep_len3", cnt, 32'd784);
    for (int a = 0; a < N; a++) rd(a);
    rd(0);   chk("mid_rd0",   data_out, 32'd0);
    rd(500); chk("mid_rd500", data_out, 32'd0);
    rd(783); chk("mid_rd783", data_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/image_memory.md
Name: image_memory

Overview:
- Single-clock, single-write/single-read word store holding one 28x28 image (784 signed 32-bit pixels).
- The drawing-grid front end writes pixels at the cursor address; the VGA renderer and the downstream neural-network reader use the read port.
- Provides a hardware zero-clear sequence after reset so every image starts blank.

Parameters:
- DEPTH, 784, number of stored words (GRID_SIZE*GRID_SIZE, row-major, addr = y*28 + x)
- DATA_WIDTH, 32, word width; contents are treated as signed
- ADDR_WIDTH, 16, width of both address ports

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- resetn  input  1  one clock; reset is synchronous and active-low
- write_addr  input  ADDR_WIDTH  write word address
- read_addr  input  ADDR_WIDTH  read word address
- data_in  input  DATA_WIDTH  signed write data
- write_enable  input  1  when 1, write data_in to write_addr on this edge
- data_out  output  DATA_WIDTH  signed registered read data
- clear_busy  output  1  high while the post-reset zero-clear sweep runs

Behaviour:
- Reset (resetn=0 at a rising edge):
  - data_out <= 0, clear_busy <= 1, clear pointer <= 0.
  - Array contents are not touched during the reset cycle itself.
- Clear sweep: begins on the first edge with resetn=1.
  - One word is zeroed per cycle, addresses 0..DEPTH-1, in 784 cycles.
  - clear_busy falls on the edge that writes address DEPTH-1.
  - During the sweep, user writes are ignored and data_out is forced to 0.
  - resetn=0 mid-sweep restarts the sweep at address 0.
- Write: on a rising edge with resetn=1, clear_busy=0, write_enable=1 and write_addr < DEPTH, mem[write_addr] <= data_in.
  - Writes to write_addr >= DEPTH are dropped; no aliasing or wrap.
- Read: registered, 1-cycle latency.
  - data_out at edge N+1 reflects read_addr sampled at edge N.
  - read_addr >= DEPTH returns 0.
- Read-during-write to the same address: write-first bypass. data_out on the next edge equals the new data_in.
- Reads and writes to different addresses are independent, one of each per cycle.
- Reads of a never-written address after a completed clear return 0.
- No other handshake: write_enable is a single-cycle strobe, and holding it high rewrites the same word each cycle.
- Arithmetic: none; data is stored verbatim, and sign is preserved (e.g. 32'hFFFFFFFF reads back as -1).

Optional Feature:
- Macro IMAGE_MEMORY_ERR_FLAG_EN.
- Defined: adds output addr_error (1 bit), which is sticky and set on the edge after any write with write_enable=1 and write_addr >= DEPTH, or any read with read_addr >= DEPTH. Cleared only by resetn=0.
- Not defined: no addr_error port. Out-of-range accesses are still silently dropped (writes) or return 0 (reads).

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, release -> clear_busy=1 for exactly 784 cycles, then 0; reading addrs 0, 392 and 783 returns 0.
- Write/read back: after clear, write 1 to addr 29 (x=1,y=1) and -5 to addr 783; read both -> data_out = 1 and -5, each one cycle after read_addr is applied.
- Read-during-write: write_enable=1, write_addr=read_addr=100, data_in=0x12345678 -> data_out = 0x12345678 on the next edge.
- Out-of-range: write 7 to addr 784 and addr 65535, then read 784 -> data_out=0, and addr 0 remains 0. With IMAGE_MEMORY_ERR_FLAG_EN, addr_error=1 and stays set until reset.
- Write during clear: assert write_enable at addr 10 while clear_busy=1 -> after the clear, addr 10 reads 0; data_out=0 throughout the sweep.
- Reset mid-sweep: pull resetn low at sweep cycle 400 after preloading nonzero data -> the sweep restarts and takes a full 784 cycles; all words read 0 afterwards.
